bomb_countdown_ctrl: RTL and testbench
======================================

Name: bomb_countdown_ctrl

Overview:
- Sequences the per-level bomb countdown for the game.
- Latches the three-digit BCD preset time produced for the current game level and counts it down to 000 on the 1 Hz game tick.
- Applies time penalties for wrong actions and freezes the count on defuse.
- Drives the time digits shown on the display and the expired/defused status used by the top-level game FSM.

Parameters:
PENALTY_SEC, 10, seconds subtracted per penalty pulse; binary 0..99, converted internally to BCD
WARN_THRESH, 30, low_time asserts when the count is at or below this value in seconds; binary 0..999

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tick_1hz  input  1  one-clk-wide pulse once per second
load  input  1  pulse; latch the preset digits
start  input  1  pulse; begin or resume counting
pause  input  1  pulse; suspend counting
penalty  input  1  pulse; subtract PENALTY_SEC
defuse  input  1  pulse; bomb defused, freeze count
preset_three  input  4  preset hundreds digit (BCD)
preset_two  input  4  preset tens digit (BCD)
preset_one  input  4  preset ones digit (BCD)
digit_three  output  4  current hundreds digit (BCD)
digit_two  output  4  current tens digit (BCD)
digit_one  output  4  current ones digit (BCD)
state  output  3  FSM state encoding
running  output  1  high in RUN
expired  output  1  high in EXPIRED
defused  output  1  high in DEFUSED
low_time  output  1  count <= WARN_THRESH while in RUN or PAUSED

Behaviour:
- Reset:
  - Synchronous; state=IDLE, all digits 0, running/expired/defused=0.
  - rst has priority over every other input.
  - rst mid-operation aborts immediately; IDLE is visible the cycle after the rst edge.
- Timing:
  - All state and digit registers update on the clk edge that samples the pulse; the result is visible the next cycle.
  - running/expired/defused are decoded from the registered state.
  - low_time is decoded combinationally from the registered digits and state.
- State encoding: IDLE=000, ARMED=001, RUN=010, PAUSED=011, EXPIRED=100, DEFUSED=101.
- Preset latch: any preset digit >9 is latched as 9.
- IDLE:
  - load -> latch presets, go to ARMED.
  - All other inputs are ignored.
- ARMED:
  - load -> re-latch presets.
  - start with count !=000 -> RUN.
  - start with count ==000 -> EXPIRED.
  - tick, penalty and defuse are ignored.
- RUN, priority order:
  - defuse > pause > (tick/penalty).
  - defuse -> DEFUSED; digits hold, and any tick or penalty in the same cycle is discarded.
  - pause -> PAUSED; any same-cycle tick or penalty is discarded.
  - tick only -> count -= 1.
  - penalty only -> count -= PENALTY_SEC.
  - tick and penalty together -> count -= PENALTY_SEC+1 in one step.
  - If the new count <= 0: count = 000 (saturated, no wrap) and go to EXPIRED on the same edge.
  - load and start are ignored.
- PAUSED:
  - start -> RUN.
  - defuse -> DEFUSED (defuse wins if start and defuse arrive together).
  - tick and penalty are ignored; digits hold.
  - load is ignored.
- EXPIRED / DEFUSED:
  - Digits hold.
  - Only load is accepted: latch presets and go to ARMED.
- BCD arithmetic:
  - Subtraction is digit-serial with borrow: ones, then tens, then hundreds.
  - A digit that underflows becomes digit+10-borrow and propagates the borrow.
  - A borrow out of the hundreds digit means underflow -> saturate to 000.
  - Digits never leave the range 0..9.
- low_time: compare the count value (100*h + 10*t + o) against WARN_THRESH; forced to 0 outside RUN/PAUSED.

Test Plan:
- rst; load preset 3,0,0; start; 3 ticks -> digits 2,9,7, running=1, state=010, low_time=0.
- Borrow chain: preset 1,0,0, start, 1 tick -> 0,9,9; at 0,3,1 one tick -> 0,3,0 and low_time=1.
- Penalty: at 0,1,5 a penalty -> 0,0,5. Another penalty -> 0,0,0, expired=1, state=100. Ticks then change nothing; load 2,2,0 -> ARMED with 2,2,0.
- Simultaneous events: at 0,0,1, tick+defuse -> DEFUSED with 0,0,1, expired=0. At 0,2,0, tick+penalty -> 0,0,9. At 0,5,0, tick+pause -> PAUSED with 0,5,0.
- Pause/resume: in PAUSED, 5 ticks and 1 penalty -> digits unchanged. start -> RUN, the next tick decrements. load in RUN and PAUSED is ignored.
- Reset and invalid input: rst mid-RUN at 1,4,2 -> IDLE, digits 0,0,0, all flags 0. Preset 12,0,15 latches 9,0,9. Preset 0,0,0 then start -> EXPIRED the next cycle.

Source files
------------

// File: rtl/bomb_countdown_ctrl.sv
// Per-level bomb countdown: latches a BCD preset, counts it down on the 1 Hz tick,
// applies penalties, and reports running/expired/defused status to the game FSM.
module bomb_countdown_ctrl #(
   parameter int PENALTY_SEC = 10,
   parameter int WARN_THRESH = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic       penalty,
   input  logic       defuse,
   input  logic [3:0] preset_three,
   input  logic [3:0] preset_two,
   input  logic [3:0] preset_one,
   output logic [3:0] digit_three,
   output logic [3:0] digit_two,
   output logic [3:0] digit_one,
   output logic [2:0] state,
   output logic       running,
   output logic       expired,
   output logic       defused,
   output logic       low_time
);

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      ARMED   = 3'b001,
      RUN     = 3'b010,
      PAUSED  = 3'b011,
      EXPIRED = 3'b100,
      DEFUSED = 3'b101
   } state_t;

   localparam int PEN_PLUS_TICK = PENALTY_SEC + 1;

   // Subtrahends pre-converted to BCD so the datapath only ever does digit arithmetic.
   localparam logic [11:0] SUB_TICK = 12'h001;
   localparam logic [11:0] SUB_PEN  = {4'(PENALTY_SEC / 100), 4'((PENALTY_SEC / 10) % 10),
                                       4'(PENALTY_SEC % 10)};
   localparam logic [11:0] SUB_BOTH = {4'(PEN_PLUS_TICK / 100), 4'((PEN_PLUS_TICK / 10) % 10),
                                       4'(PEN_PLUS_TICK % 10)};

   state_t      state_q, state_d;
   logic [11:0] digits_q, digits_d;
   logic [11:0] preset_s;
   logic [11:0] sub_s;
   logic [12:0] diff_s;
   logic [9:0]  count_val_s;

   function automatic logic [3:0] clamp_digit(input logic [3:0] x);
      logic [3:0] r;
      if (x > 4'd9) begin
         r = 4'd9;
      end else begin
         r = x;
      end
      return r;
   endfunction

   // Returns {borrow_out, result}; borrow_out set means the minuend was smaller.
   function automatic logic [12:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
      logic [4:0]  d;
      logic        br;
      logic [11:0] r;
      br = 1'b0;
      r  = 12'h000;
      for (int i = 0; i < 3; i++) begin
         d = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, br};
         if (d[4]) begin
            r[i*4 +: 4] = d[3:0] + 4'd10;
            br          = 1'b1;
         end else begin
            r[i*4 +: 4] = d[3:0];
            br          = 1'b0;
         end
      end
      return {br, r};
   endfunction

   assign preset_s = {clamp_digit(preset_three), clamp_digit(preset_two), clamp_digit(preset_one)};

   // Subtrahend selection for the RUN decrement.
   always_comb begin
      sub_s = 12'h000;
      case ({tick_1hz, penalty})
         2'b10:   sub_s = SUB_TICK;
         2'b01:   sub_s = SUB_PEN;
         2'b11:   sub_s = SUB_BOTH;
         default: sub_s = 12'h000;
      endcase
   end

   assign diff_s = bcd_sub(digits_q, sub_s);

   // Next-state and next-count logic.
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               digits_d = preset_s;
               state_d  = ARMED;
            end else begin
               state_d  = IDLE;
            end
         end
         ARMED: begin
            if (load) begin
               digits_d = preset_s;
            end else if (start) begin
               state_d = (digits_q != 12'h000) ? RUN : EXPIRED;
            end else begin
               state_d = ARMED;
            end
         end
         RUN: begin
            if (defuse) begin
               state_d = DEFUSED;
            end else if (pause) begin
               state_d = PAUSED;
            end else if (tick_1hz || penalty) begin
               // Reaching exactly zero expires as well as underflowing past it.
               if (diff_s[12] || (diff_s[11:0] == 12'h000)) begin
                  digits_d = 12'h000;
                  state_d  = EXPIRED;
               end else begin
                  digits_d = diff_s[11:0];
               end
            end else begin
               state_d = RUN;
            end
         end
         PAUSED: begin
            if (defuse) begin
               state_d = DEFUSED;
            end else if (start) begin
               state_d = RUN;
            end else begin
               state_d = PAUSED;
            end
         end
         EXPIRED, DEFUSED: begin
            if (load) begin
               digits_d = preset_s;
               state_d  = ARMED;
            end else begin
               state_d  = state_q;
            end
         end
         default: begin
            state_d  = IDLE;
            digits_d = 12'h000;
         end
      endcase
   end

   // State and count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         digits_q <= 12'h000;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
      end
   end

   assign count_val_s = ({6'd0, digits_q[11:8]} * 10'd100) + ({6'd0, digits_q[7:4]} * 10'd10)
                      + {6'd0, digits_q[3:0]};

   assign digit_three = digits_q[11:8];
   assign digit_two   = digits_q[7:4];
   assign digit_one   = digits_q[3:0];
   assign state       = state_q;
   assign running     = (state_q == RUN);
   assign expired     = (state_q == EXPIRED);
   assign defused     = (state_q == DEFUSED);
   assign low_time    = ((state_q == RUN) || (state_q == PAUSED))
                        && (count_val_s <= 10'(WARN_THRESH));

endmodule

// File: tb/tb_bomb_countdown_ctrl.sv
// Directed test-plan steps followed by random pulses, checked against an integer-count model.
module tb_bomb_countdown_ctrl;

   localparam int P = 10;
   localparam int W = 30;

   localparam logic [6:0] E_NONE  = 7'b0000000;
   localparam logic [6:0] E_RST   = 7'b1000000;
   localparam logic [6:0] E_LOAD  = 7'b0100000;
   localparam logic [6:0] E_START = 7'b0010000;
   localparam logic [6:0] E_PAUSE = 7'b0001000;
   localparam logic [6:0] E_PEN   = 7'b0000100;
   localparam logic [6:0] E_DEF   = 7'b0000010;
   localparam logic [6:0] E_TICK  = 7'b0000001;

   logic       clk = 1'b0;
   logic       rst, tick_1hz, load, start, pause, penalty, defuse;
   logic [3:0] preset_three, preset_two, preset_one;
   logic [3:0] digit_three, digit_two, digit_one;
   logic [2:0] state;
   logic       running, expired, defused, low_time;

   int n_tests = 0;
   int n_fail  = 0;
   int m_cnt   = 0;
   int m_st    = 0;

   bomb_countdown_ctrl #(.PENALTY_SEC(P), .WARN_THRESH(W)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .load(load), .start(start),
      .pause(pause), .penalty(penalty), .defuse(defuse),
      .preset_three(preset_three), .preset_two(preset_two), .preset_one(preset_one),
      .digit_three(digit_three), .digit_two(digit_two), .digit_one(digit_one),
      .state(state), .running(running), .expired(expired), .defused(defused),
      .low_time(low_time)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int min9(input logic [3:0] x);
      return (int'(x) > 9) ? 9 : int'(x);
   endfunction

   // Behavioural model: count kept as a plain integer of seconds.
   task automatic model(input logic [6:0] ev);
      int n;
      int pv;
      pv = 100 * min9(preset_three) + 10 * min9(preset_two) + min9(preset_one);
      if (ev[6]) begin
         m_st = 0; m_cnt = 0;
      end else begin
         case (m_st)
            0: if (ev[5]) begin m_cnt = pv; m_st = 1; end
            1: begin
               if (ev[5]) m_cnt = pv;
               else if (ev[4]) m_st = (m_cnt != 0) ? 2 : 4;
            end
            2: begin
               if (ev[1]) m_st = 5;
               else if (ev[3]) m_st = 3;
               else if (ev[0] || ev[2]) begin
                  n = m_cnt - (ev[0] ? 1 : 0) - (ev[2] ? P : 0);
                  if (n <= 0) begin m_cnt = 0; m_st = 4; end
                  else m_cnt = n;
               end
            end
            3: begin
               if (ev[1]) m_st = 5;
               else if (ev[4]) m_st = 2;
            end
            4, 5: if (ev[5]) begin m_cnt = pv; m_st = 1; end
            default: m_st = 0;
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      logic [11:0] exp_d;
      logic        exp_low;
      exp_d   = {4'(m_cnt / 100), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)};
      exp_low = ((m_st == 2) || (m_st == 3)) && (m_cnt <= W);
      chk({tag, "/digits"}, {digit_three, digit_two, digit_one}, exp_d);
      chk({tag, "/state"}, {9'd0, state}, 12'(m_st));
      chk({tag, "/flags"}, {8'd0, running, expired, defused, low_time},
          {8'd0, (m_st == 2), (m_st == 4), (m_st == 5), exp_low});
   endtask

   task automatic step(input logic [6:0] ev, input string tag);
      {rst, load, start, pause, penalty, defuse, tick_1hz} = ev;
      @(posedge clk);
      model(ev);
      #1;
      {rst, load, start, pause, penalty, defuse, tick_1hz} = E_NONE;
      check_all(tag);
   endtask

   task automatic preset(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      preset_three = h; preset_two = t; preset_one = o;
   endtask

   initial begin
      {rst, load, start, pause, penalty, defuse, tick_1hz} = E_NONE;
      preset(4'd0, 4'd0, 4'd0);
      @(posedge clk); #1;

      step(E_RST, "reset");
      chk("reset_const", {digit_three, digit_two, digit_one, 1'b0, state[1:0], running}, 12'h000);

      preset(4'd3, 4'd0, 4'd0);
      step(E_LOAD, "load300");
      step(E_START, "start300");
      for (int i = 0; i < 3; i++) step(E_TICK, "tick300");
      chk("run297_digits", {digit_three, digit_two, digit_one}, 12'h297);
      chk("run297_state", {9'd0, state}, 12'h002);
      chk("run297_flags", {10'd0, running, low_time}, 12'h002);

      step(E_RST, "rst2");
      preset(4'd1, 4'd0, 4'd0);
      step(E_LOAD, "load100"); step(E_START, "start100"); step(E_TICK, "tick100");
      chk("borrow099", {digit_three, digit_two, digit_one}, 12'h099);

      step(E_RST, "rst3");
      preset(4'd0, 4'd3, 4'd1);
      step(E_LOAD, "load031"); step(E_START, "start031");
      chk("low_at31", {11'd0, low_time}, 12'h000);
      step(E_TICK, "tick031");
      chk("low_at30", {digit_three, digit_two, digit_one, 4'd0} >> 4 | {11'd0, low_time}, 12'h031);

      step(E_RST, "rst4");
      preset(4'd0, 4'd1, 4'd5);
      step(E_LOAD, "load015"); step(E_START, "start015");
      step(E_PEN, "pen015");
      chk("pen005", {digit_three, digit_two, digit_one}, 12'h005);
      step(E_PEN, "pen005");
      chk("sat000_state", {9'd0, state}, 12'h004);
      chk("sat000_exp", {digit_three, digit_two, digit_one, 3'd0, expired}, 12'h001);
      step(E_TICK, "exp_tick1"); step(E_TICK | E_PEN, "exp_tick2");
      preset(4'd2, 4'd2, 4'd0);
      step(E_LOAD, "exp_load220");
      chk("armed220", {digit_three, digit_two, digit_one}, 12'h220);
      chk("armed_state", {9'd0, state}, 12'h001);

      step(E_RST, "rst5");
      preset(4'd0, 4'd0, 4'd1);
      step(E_LOAD, "load001"); step(E_START, "start001");
      step(E_TICK | E_DEF, "tick_def");
      chk("def001", {digit_three, digit_two, digit_one}, 12'h001);
      chk("def_flags", {10'd0, expired, defused}, 12'h001);

      preset(4'd0, 4'd2, 4'd0);
      step(E_LOAD, "load020"); step(E_START, "start020");
      step(E_TICK | E_PEN, "tick_pen");
      chk("tp009", {digit_three, digit_two, digit_one}, 12'h009);

      step(E_RST, "rst6");
      preset(4'd0, 4'd5, 4'd0);
      step(E_LOAD, "load050"); step(E_START, "start050");
      step(E_TICK | E_PAUSE, "tick_pause");
      chk("paused050", {digit_three, digit_two, digit_one}, 12'h050);
      chk("paused_state", {9'd0, state}, 12'h003);
      for (int i = 0; i < 5; i++) step(E_TICK, "paused_tick");
      step(E_PEN, "paused_pen");
      preset(4'd9, 4'd9, 4'd9);
      step(E_LOAD, "paused_load");
      chk("paused_hold", {digit_three, digit_two, digit_one}, 12'h050);
      step(E_START, "resume");
      step(E_LOAD, "run_load");
      step(E_TICK, "resume_tick");
      chk("resume049", {digit_three, digit_two, digit_one}, 12'h049);

      step(E_RST, "rst7");
      preset(4'd1, 4'd4, 4'd2);
      step(E_LOAD, "load142"); step(E_START, "start142");
      step(E_RST, "rst_mid_run");
      chk("rst_mid", {digit_three, digit_two, digit_one} | {state, running, expired, defused, 6'd0},
          12'h000);

      preset(4'd12, 4'd0, 4'd15);
      step(E_LOAD, "load_invalid");
      chk("clamp909", {digit_three, digit_two, digit_one}, 12'h909);

      step(E_RST, "rst8");
      preset(4'd0, 4'd0, 4'd0);
      step(E_LOAD, "load000"); step(E_START, "start000");
      chk("zero_start", {9'd0, state}, 12'h004);

      for (int i = 0; i < 800; i++) begin
         logic [6:0] ev;
         ev = E_NONE;
         if ($urandom_range(0, 99) < 2)  ev |= E_RST;
         if ($urandom_range(0, 99) < 8)  ev |= E_LOAD;
         if ($urandom_range(0, 99) < 12) ev |= E_START;
         if ($urandom_range(0, 99) < 5)  ev |= E_PAUSE;
         if ($urandom_range(0, 99) < 10) ev |= E_PEN;
         if ($urandom_range(0, 99) < 3)  ev |= E_DEF;
         if ($urandom_range(0, 99) < 50) ev |= E_TICK;
         preset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         step(ev, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
